spi_dep_miso_transmitter: RTL and testbench



---
 rtl/spi_dep_miso_transmitter.sv | 99 +++++++++
 tb/tb_spi_dep_miso_transmitter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/spi_dep_miso_transmitter.sv
// SPI mode-0 target transmitter: edge-detects pre-synchronized SCLK/CS and
// shifts buffered words out on MISO, MSB first, with a one-entry holding buffer.
module spi_dep_miso_transmitter #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic              word_done_o,
  output logic              underrun_o,
  output logic              abort_o
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DATA_W);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state;
  logic              sclk_q, cs_n_q;
  logic [DATA_W-1:0] buf_q, shift_q;
  logic              buf_full;
  logic [CW-1:0]     bit_cnt;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, accept, load;

  assign sclk_rise  = sclk_i & ~sclk_q;
  assign sclk_fall  = ~sclk_i & sclk_q;
  assign cs_fall    = ~cs_n_i & cs_n_q;
  assign cs_rise    = cs_n_i & ~cs_n_q;
  assign accept     = tx_valid_i & ~buf_full;
  assign tx_ready_o = ~buf_full;
  // Word boundary inside a frame reuses the same load path as the frame start.
  assign load = cs_fall | ((state == ACTIVE) & sclk_fall & (bit_cnt == FULL_CNT));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      buf_q       <= '0;
      buf_full    <= 1'b0;
      shift_q     <= '0;
      bit_cnt     <= '0;
      miso_o      <= 1'b0;
      miso_oe_o   <= 1'b0;
      word_done_o <= 1'b0;
      underrun_o  <= 1'b0;
      abort_o     <= 1'b0;
    end else begin
      sclk_q      <= sclk_i;
      cs_n_q      <= cs_n_i;
      miso_oe_o   <= ~cs_n_i;
      word_done_o <= 1'b0;
      underrun_o  <= 1'b0;
      abort_o     <= 1'b0;

      // Accept never bypasses into the shifter; it only fills an empty buffer.
      if (accept) begin
        buf_q    <= tx_data_i;
        buf_full <= 1'b1;
      end

      if (cs_rise) begin
        state   <= IDLE;
        abort_o <= (bit_cnt != '0) && (bit_cnt < FULL_CNT);
        bit_cnt <= '0;
        shift_q <= '0;
        miso_o  <= 1'b0;
      end else if (load) begin
        state   <= ACTIVE;
        bit_cnt <= '0;
        if (buf_full) begin
          shift_q  <= buf_q;
          miso_o   <= buf_q[DATA_W-1];
          buf_full <= 1'b0;
        end else begin
          shift_q    <= IDLE_WORD;
          miso_o     <= IDLE_WORD[DATA_W-1];
          underrun_o <= 1'b1;
        end
      end else if (state == ACTIVE && sclk_rise) begin
        if (bit_cnt < FULL_CNT) begin
          bit_cnt     <= bit_cnt + CW'(1);
          word_done_o <= (bit_cnt + CW'(1)) == FULL_CNT;
        end
      end else if (state == ACTIVE && sclk_fall && bit_cnt < FULL_CNT) begin
        shift_q <= {shift_q[DATA_W-2:0], 1'b0};
        miso_o  <= shift_q[DATA_W-2];
      end
    end
  end
endmodule

// File: tb/tb_spi_dep_miso_transmitter.sv
// Directed bench: table of single-word frames plus hand-written corner sequences.
module tb_spi_dep_miso_transmitter;
  logic       clk = 0, reset = 1, sclk = 0, cs_n = 1, tx_valid = 0;
  logic [7:0] tx_data = '0;
  logic       tx_ready, miso, miso_oe, word_done, underrun, abort_p;

  spi_dep_miso_transmitter #(.DATA_W(8), .IDLE_WORD(8'h00)) dut (
    .clk_i(clk), .reset_i(reset), .sclk_i(sclk), .cs_n_i(cs_n),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .miso_o(miso), .miso_oe_o(miso_oe), .word_done_o(word_done),
    .underrun_o(underrun), .abort_o(abort_p)
  );

  always #5 clk = ~clk;

  int n_done = 0, n_under = 0, n_abort = 0;
  always @(negedge clk) begin
    if (word_done) n_done  <= n_done + 1;
    if (underrun)  n_under <= n_under + 1;
    if (abort_p)   n_abort <= n_abort + 1;
  end

  int total = 0, passed = 0;
  logic [31:0] samp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 200) begin cyc(1); n++; end
    if (n >= 200) chk("push_timeout", 0, 1);
    tx_data = d; tx_valid = 1; cyc(1); tx_valid = 0;
  endtask

  // Master samples MISO just before raising SCLK.
  task automatic rise_only();
    samp = {samp[30:0], miso};
    sclk = 1; cyc(2);
  endtask

  task automatic rise_fall(input int n);
    for (int i = 0; i < n; i++) begin
      rise_only();
      sclk = 0; cyc(2);
    end
  endtask

  task automatic end_frame();
    sclk = 0; cyc(2); cs_n = 1; cyc(2);
  endtask

  typedef struct {
    bit         has;
    logic [7:0] data;
    logic [7:0] exp;
    int         exp_un;
  } vec_t;
  vec_t vt[6];

  int d0, u0, a0;

  initial begin
    vt[0] = '{1, 8'hA5, 8'hA5, 0};
    vt[1] = '{1, 8'h00, 8'h00, 0};
    vt[2] = '{1, 8'hFF, 8'hFF, 0};
    vt[3] = '{0, 8'h00, 8'h00, 1};
    vt[4] = '{1, 8'h81, 8'h81, 0};
    vt[5] = '{1, 8'h3C, 8'h3C, 0};

    cyc(3); reset = 0; cyc(1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_miso", miso, 0);
    chk("rst_oe", miso_oe, 0);
    chk("rst_pulses", {word_done, underrun, abort_p}, 0);

    foreach (vt[i]) begin
      if (vt[i].has) begin
        push(vt[i].data);
        chk($sformatf("v%0d_ready_full", i), tx_ready, 0);
      end
      d0 = n_done; u0 = n_under; a0 = n_abort; samp = 0;
      cs_n = 0; cyc(1);
      chk($sformatf("v%0d_underrun_at_fall", i), underrun, vt[i].exp_un != 0);
      chk($sformatf("v%0d_ready_after_fall", i), tx_ready, 1);
      chk($sformatf("v%0d_oe", i), miso_oe, 1);
      cyc(1);
      rise_fall(7);
      chk($sformatf("v%0d_no_early_done", i), n_done - d0, 0);
      rise_only();
      chk($sformatf("v%0d_data", i), samp[7:0], vt[i].exp);
      chk($sformatf("v%0d_done", i), n_done - d0, 1);
      chk($sformatf("v%0d_under", i), n_under - u0, vt[i].exp_un);
      chk($sformatf("v%0d_abort", i), n_abort - a0, 0);
      end_frame();
    end

    // back-to-back words in one frame
    push(8'h3C);
    d0 = n_done; u0 = n_under; samp = 0;
    cs_n = 0; cyc(2);
    rise_fall(2);
    push(8'hF0);
    rise_fall(13);
    rise_only();
    chk("b2b_data", samp[15:0], 16'h3CF0);
    chk("b2b_done", n_done - d0, 2);
    chk("b2b_under", n_under - u0, 0);
    end_frame();

    // underrun then mid-word push
    u0 = n_under; samp = 0;
    cs_n = 0; cyc(1);
    chk("ur_pulse", underrun, 1);
    cyc(1);
    rise_fall(4);
    push(8'h81);
    rise_fall(11);
    rise_only();
    chk("ur_data", samp[15:0], 16'h0081);
    chk("ur_count", n_under - u0, 1);
    end_frame();

    // abort after 3 rises, then a clean frame
    push(8'hFF);
    a0 = n_abort; samp = 0;
    cs_n = 0; cyc(2);
    rise_fall(3);
    cs_n = 1; cyc(1);
    chk("ab_pulse", abort_p, 1);
    chk("ab_oe", miso_oe, 0);
    chk("ab_miso", miso, 0);
    cyc(2);
    chk("ab_count", n_abort - a0, 1);
    push(8'h12);
    samp = 0; cs_n = 0; cyc(2);
    rise_fall(7); rise_only();
    chk("ab_next_data", samp[7:0], 8'h12);
    end_frame();

    // cs_fall coincident with an SCLK rise: that rise is not counted
    push(8'hA5);
    d0 = n_done;
    cs_n = 0; sclk = 1; cyc(2); sclk = 0; cyc(2);
    rise_fall(7);
    chk("sim_cs_no_done", n_done - d0, 0);
    rise_only();
    chk("sim_cs_done", n_done - d0, 1);
    end_frame();

    // tx_valid in the load cycle with an empty buffer
    samp = 0;
    cs_n = 0; tx_data = 8'h5A; tx_valid = 1; cyc(1); tx_valid = 0;
    chk("sim_ld_under", underrun, 1);
    chk("sim_ld_ready", tx_ready, 0);
    cyc(1);
    rise_fall(15); rise_only();
    chk("sim_ld_data", samp[15:0], 16'h005A);
    end_frame();

    // reset mid-frame discards shifter and buffer
    push(8'hC3);
    cs_n = 0; cyc(2);
    rise_fall(4);
    push(8'h33);
    chk("rmf_buf_full", tx_ready, 0);
    sclk = 1; cyc(1);
    reset = 1; cs_n = 1; sclk = 0; cyc(1);
    chk("rmf_miso", miso, 0);
    chk("rmf_oe", miso_oe, 0);
    chk("rmf_ready", tx_ready, 1);
    chk("rmf_pulses", {word_done, underrun, abort_p}, 0);
    cyc(1); reset = 0; cyc(2);
    chk("rmf_no_abort", abort_p, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
